audio_sof_sched: RTL
====================

# audio_sof_sched

SOF-locked sample scheduler for the USB audio SoC. It sits between the USB core's `usb_sof` pulse and the PCM audio datapath. It measures the host frame period in `clk_24m` cycles, then uses a fractional accumulator to emit exactly `SPF` evenly spaced sample ticks per USB frame. It is a Wishbone slave on the CPU bus, where firmware enables it and reads lock, period and error status.

## Interface
Parameters:
- `SPF`, default 48: sample ticks per USB frame; must satisfy 0 < `SPF` < `PER_MIN`.
- `CNT_W`, default 16: width of the cycle counter and period register.
- `PER_NOM`, default 24000: reset value of the period register (1 ms at 24 MHz).
- `PER_MIN`, default 23000: smallest SOF interval accepted as valid.
- `PER_MAX`, default 25000: largest SOF interval accepted as valid.
- `TIMEOUT`, default 48000: cycles without SOF before lock is dropped; must be less than 2^`CNT_W`.

Ports:
- `clk_24m`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `usb_sof`, in, 1: single-cycle SOF strobe, already synchronous to `clk_24m`.
- `audio_tick`, out, 1: single-cycle sample strobe to the PCM block.
- `locked`, out, 1: high while the state is LOCKED.
- `wb_addr`, in, 2: register select.
- `wb_rdata`, out, 32: read data, valid only while `wb_ack` is high and zero otherwise.
- `wb_wdata`, in, 32: write data.
- `wb_we`, in, 1: write enable.
- `wb_cyc`, in, 1: cycle request.
- `wb_ack`, out, 1: acknowledge.

## Operation
- `cnt` (`CNT_W` bits):
  - cleared on every `usb_sof`, otherwise increments.
  - saturates at `TIMEOUT`.
  - SOF interval = `cnt`+1 sampled on the SOF cycle.
  - valid when `PER_MIN` ≤ interval ≤ `PER_MAX`.
- State machine with three states; any write of `en`=0 forces IDLE on the next cycle from any state.
  - IDLE (encoding 0): `audio_tick` is held low.
    - `usb_sof` while `en`=1 → MEASURE.
  - MEASURE (encoding 1):
    - SOF with a valid interval → `period` ← interval, `acc` ← 0, go to LOCKED.
    - SOF with an invalid interval → stay in MEASURE.
    - `cnt` = `TIMEOUT`-1 → IDLE.
  - LOCKED (encoding 2):
    - SOF with a valid interval → `period` ← interval; `acc` is NOT reset, so phase stays continuous.
    - SOF with an invalid interval → `period` unchanged, `err_cnt` increments, state unchanged.
    - `cnt` = `TIMEOUT`-1 → IDLE, `err_cnt` increments.
- Accumulator (`CNT_W`+1 bits, active in LOCKED only):
  - each cycle compute s = `acc` + `SPF`.
  - if s ≥ `period`: `acc` ← s − `period` and the registered `audio_tick` ← 1.
  - otherwise `acc` ← s and `audio_tick` ← 0.
  - a `period` update on a SOF cycle takes effect on the following cycle.
- Frame statistics:
  - `ftc` counts `audio_tick` high cycles.
  - on each SOF in LOCKED: `last_ftc` ← `ftc` + `audio_tick` (a tick coincident with SOF belongs to the closing frame), `ftc` ← 0, `frame_no` increments (8-bit, wraps 255→0).
- `err_cnt` is 8-bit and saturates at 255.
- Registers (reads return 0 in unused bits):
  - 0, control/status (R/W).
    - write: bit0 = `en`; bit1 = 1 clears `err_cnt` (self-clearing).
    - read: [0] `en`, [2:1] state, [15:8] `err_cnt`.
  - 1, read-only: [`CNT_W`-1:0] `period`.
  - 2, read-only: [7:0] `last_ftc`, [15:8] `frame_no`.
  - 3: reads 0; writes ignored.

## Timing
- Reset values:
  - state IDLE, `en` 0, `period` = `PER_NOM`.
  - `cnt`, `acc`, `ftc`, `last_ftc`, `frame_no`, `err_cnt` all 0.
  - `audio_tick` 0, `locked` 0, `wb_ack` 0, `wb_rdata` 0.
- Wishbone:
  - `wb_ack` ← `wb_cyc` & ~`wb_ack`: a single-cycle ack one cycle after `cyc` is asserted.
  - writes take effect on the ack cycle.
  - back-to-back accesses cost 2 cycles each.
- `locked` rises the cycle after the validating SOF; the first `audio_tick` follows within `period`/`SPF` cycles.
- If an error-clear write and an `err_cnt` increment land in the same cycle, the clear wins.
- If `rst` asserts mid-frame, all state returns to reset values immediately, with no partial tick.
- With `period`=24000 and `SPF`=48, `audio_tick` fires exactly every 500 cycles.

## Test plan
- Nominal lock: `en`=1, SOF every 24000 cycles. Required response:
  - LOCKED after the 2nd SOF.
  - tick spacing 500 cycles.
  - `last_ftc`=48 every frame.
  - period reg = 24000.
- Fractional rate: SOF every 24001 cycles. Required response:
  - `last_ftc` always 47 or 48, averaging 48 over 100 frames.
  - tick spacing 500 or 501.
  - no `err_cnt` change.
- Jitter/invalid interval: one SOF arrives at 20000 cycles, others at 24000. Required response:
  - `err_cnt`=1, `period` stays 24000.
  - state stays LOCKED and ticks continue.
- Timeout: stop SOF after lock. Required response:
  - IDLE 48000 cycles after the last SOF.
  - `locked`=0, `err_cnt`+1, no further ticks.
  - next two valid SOFs relock.
- Enable/clear: write `en`=0 mid-frame, then write reg0=0x2. Required response:
  - IDLE and `audio_tick` low from the next cycle.
  - `err_cnt` reads 0.
  - `wb_ack` is exactly 1 cycle wide per access.
- Reset mid-operation: assert `rst` while LOCKED. Required response:
  - all outputs 0 and `period` reads 24000.
  - relock takes 2 SOFs after `en`=1.

Source files
------------

// File: rtl/audio_sof_sched.sv
// audio_sof_sched: measures the USB SOF period and emits SPF evenly
// spaced sample ticks per frame; Wishbone control and status registers.
module audio_sof_sched #(
    parameter int SPF     = 48,
    parameter int CNT_W   = 16,
    parameter int PER_NOM = 24000,
    parameter int PER_MIN = 23000,
    parameter int PER_MAX = 25000,
    parameter int TIMEOUT = 48000
) (
    input  logic        clk_24m,
    input  logic        rst,
    input  logic        usb_sof,
    output logic        audio_tick,
    output logic        locked,
    input  logic [1:0]  wb_addr,
    output logic [31:0] wb_rdata,
    input  logic [31:0] wb_wdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack
);

    localparam int AW = CNT_W + 1;
    localparam logic [CNT_W-1:0] TO_SAT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_END = CNT_W'(TIMEOUT - 1);
    localparam logic [AW-1:0]    P_MIN  = AW'(PER_MIN);
    localparam logic [AW-1:0]    P_MAX  = AW'(PER_MAX);
    localparam logic [AW-1:0]    STEP   = AW'(SPF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEAS = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             tick_q, tick_d;
    logic             en_q, en_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       ftc_q, ftc_d;
    logic [7:0]       lftc_q, lftc_d;
    logic [7:0]       fno_q, fno_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [AW-1:0] interval;
    logic [AW-1:0] acc_sum;
    logic          iv_ok;
    logic          wrap;
    logic          access;
    logic          wr_ctrl;
    logic          timeout_hit;
    logic          err_inc;
    logic          unused_wdata;

    assign access      = wb_cyc & ~ack_q;
    assign wr_ctrl     = access & wb_we & (wb_addr == 2'd0);
    assign interval    = {1'b0, cnt_q} + AW'(1);
    assign iv_ok       = (interval >= P_MIN) && (interval <= P_MAX);
    assign acc_sum     = acc_q + STEP;
    assign wrap        = acc_sum >= {1'b0, period_q};
    assign timeout_hit = cnt_q == TO_END;
    assign unused_wdata = ^wb_wdata[31:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        acc_d    = '0;
        tick_d   = 1'b0;
        en_d     = en_q;
        err_d    = err_q;
        ftc_d    = ftc_q;
        lftc_d   = lftc_q;
        fno_d    = fno_q;
        ack_d    = access;
        rdata_d  = '0;
        err_inc  = 1'b0;

        if (usb_sof) begin
            cnt_d = '0;
        end else if (cnt_q != TO_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (usb_sof && en_q) state_d = S_MEAS;
            end
            S_MEAS: begin
                if (usb_sof) begin
                    if (iv_ok) begin
                        period_d = interval[CNT_W-1:0];
                        state_d  = S_LOCK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                if (usb_sof) begin
                    if (iv_ok) period_d = interval[CNT_W-1:0];
                    else       err_inc  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_ctrl) begin
            en_d = wb_wdata[0];
            if (!wb_wdata[0]) state_d = S_IDLE;
        end

        // Phase keeps running across period updates; only entering LOCKED zeroes it.
        if (state_q == S_LOCK) begin
            acc_d  = wrap ? acc_sum - {1'b0, period_q} : acc_sum;
            tick_d = wrap && (state_d == S_LOCK);
        end

        if (state_q != S_LOCK) begin
            ftc_d = '0;
        end else if (usb_sof) begin
            lftc_d = ftc_q + {7'd0, tick_q};
            ftc_d  = '0;
            fno_d  = fno_q + 8'd1;
        end else if (tick_q) begin
            ftc_d = ftc_q + 8'd1;
        end

        if (wr_ctrl && wb_wdata[1]) begin
            err_d = '0;
        end else if (err_inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end

        if (access) begin
            case (wb_addr)
                2'd0:    rdata_d = {16'd0, err_q, 5'd0, state_q, en_q};
                2'd1:    rdata_d = 32'(period_q);
                2'd2:    rdata_d = {16'd0, fno_q, lftc_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= CNT_W'(PER_NOM);
            acc_q    <= '0;
            tick_q   <= 1'b0;
            en_q     <= 1'b0;
            err_q    <= '0;
            ftc_q    <= '0;
            lftc_q   <= '0;
            fno_q    <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            acc_q    <= acc_d;
            tick_q   <= tick_d;
            en_q     <= en_d;
            err_q    <= err_d;
            ftc_q    <= ftc_d;
            lftc_q   <= lftc_d;
            fno_q    <= fno_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign audio_tick = tick_q;
    assign locked     = state_q == S_LOCK;
    assign wb_ack     = ack_q;
    assign wb_rdata   = rdata_q;

endmodule
